stp_frame_ctrl: RTL and testbench

Sequencer for the tensor-core serial-to-parallel input path. It frames a strobed serial bit stream into WORD_W-bit words, shifting MSB-first, and counts bits per word. Completed words go into a one-deep output register with a valid/ready handshake. It supports single-word and continuous capture, mid-word abort, and a sticky overrun flag for words dropped while the consumer stalls.

---
 rtl/stp_pkg.sv | 5 +
 rtl/stp_frame_ctrl_bit_counter.sv | 21 ++
 rtl/stp_frame_ctrl.sv | 66 ++++++
 tb/tb_stp_frame_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stp_pkg.sv
// stp_pkg: shared tensor-core serial-to-parallel types and default word width
package stp_pkg;
    typedef enum logic {IDLE, SHIFT} stp_state_t;
    localparam int STP_WORD_W = 8;
endpackage

// File: rtl/stp_frame_ctrl_bit_counter.sv
// stp_bit_counter: modulo-WORD_W bit counter; clk, rst_n, en, clr in; count, last (count=WORD_W-1) out
module stp_bit_counter
    import stp_pkg::*;
#(
    parameter int WORD_W = STP_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    assign last = count == CNT_W'(WORD_W - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= last ? '0 : count + CNT_W'(1);
    end
endmodule

// File: rtl/stp_frame_ctrl.sv
// stp_frame_ctrl: frames strobed serial bits MSB-first into words; ports: clk, rst_n, start/cont/stop control, in_valid/serial_in stream, word_out/word_valid/word_ready handshake, busy, bit_cnt, overrun/clear_err
module stp_frame_ctrl
    import stp_pkg::*;
#(
    parameter int WORD_W = STP_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              stop,
    input  logic              in_valid,
    input  logic              serial_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              overrun,
    input  logic              clear_err
);
    stp_state_t state, state_d;
    logic cont_q;
    logic [WORD_W-2:0] shreg;
    logic last, strobe, done, load;
    logic [WORD_W-1:0] word_new;
    // stop wins over a coinciding bit, so the final bit of an aborted word never completes it
    assign strobe   = state == SHIFT && in_valid && !stop;
    assign done     = strobe && last;
    assign word_new = {shreg, serial_in};
    assign load     = done && (!word_valid || word_ready);
    assign busy     = state == SHIFT;
    stp_bit_counter #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (strobe),
        .clr   (state != SHIFT || stop),
        .count (bit_cnt),
        .last  (last)
    );
    always_comb begin
        state_d = state;
        if (state == IDLE) state_d = start ? SHIFT : IDLE;
        else if (stop || (done && !cont_q)) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cont_q     <= 1'b0;
            shreg      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && start) cont_q <= cont;
            if (state != SHIFT || stop) shreg <= '0;
            else if (strobe) shreg <= done ? '0 : word_new[WORD_W-2:0];
            if (load) word_out <= word_new;
            word_valid <= load ? 1'b1 : (word_valid && !word_ready);
            // a drop sets overrun even when clear_err is asserted in the same cycle
            overrun <= (done && !load) ? 1'b1 : (clear_err ? 1'b0 : overrun);
        end
    end
endmodule

// File: tb/tb_stp_frame_ctrl.sv
module tb_stp_frame_ctrl;
    logic clk = 0, rst_n = 0;
    logic start = 0, cont = 0, stop = 0, in_valid = 0, serial_in = 0;
    logic word_ready = 0, clear_err = 0;
    logic [7:0] word_out;
    logic word_valid, busy, overrun;
    logic [2:0] bit_cnt;
    int n_chk = 0, n_fail = 0;

    stp_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
        .in_valid(in_valid), .serial_in(serial_in), .word_out(word_out),
        .word_valid(word_valid), .word_ready(word_ready), .busy(busy),
        .bit_cnt(bit_cnt), .overrun(overrun), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_capture(input logic c);
        start = 1; cont = c;
        tick();
        start = 0; cont = 0;
    endtask

    task automatic send(input logic [7:0] w, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1; serial_in = w[7-i];
            tick();
            if (gap) begin
                in_valid = 0;
                tick();
            end
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_word_out", word_out, 8'h00);
        chk("rst_valid", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0]; serial_in = ~i[0];
            tick();
        end
        in_valid = 0;
        chk("idle_cnt", bit_cnt, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", word_valid, 0);

        word_ready = 1;
        begin_capture(0);
        chk("single_busy", busy, 1);
        send(8'hB2, 8, 0);
        in_valid = 0;
        chk("single_valid", word_valid, 1);
        chk("single_word", word_out, 8'hB2);
        chk("single_busy_after", busy, 0);
        tick();
        chk("single_drained", word_valid, 0);

        begin_capture(0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; serial_in = 8'hB2 >> (7 - i);
            tick();
            in_valid = 0;
            if (i == 2) chk("gap_cnt_strobe", bit_cnt, 3);
            tick();
            if (i == 2) chk("gap_cnt_hold", bit_cnt, 3);
            if (i == 6) chk("gap_cnt_7", bit_cnt, 7);
            if (i == 7) chk("gap_cnt_wrap", bit_cnt, 0);
        end
        chk("gap_word", word_out, 8'hB2);
        chk("gap_busy", busy, 0);

        word_ready = 0;
        tick();
        begin_capture(1);
        send(8'hA5, 8, 0);
        chk("bp_valid1", word_valid, 1);
        chk("bp_word1", word_out, 8'hA5);
        chk("bp_ovr1", overrun, 0);
        chk("bp_busy1", busy, 1);
        send(8'h3C, 8, 0);
        chk("bp_word2", word_out, 8'hA5);
        chk("bp_ovr2", overrun, 1);
        send(8'hFF, 8, 0);
        in_valid = 0;
        chk("bp_word3", word_out, 8'hA5);
        chk("bp_busy3", busy, 1);
        stop = 1; tick(); stop = 0;
        chk("bp_stop_busy", busy, 0);
        clear_err = 1; tick();
        chk("bp_clear", overrun, 0);
        begin_capture(0);
        send(8'h11, 8, 0);
        in_valid = 0;
        clear_err = 0;
        chk("set_beats_clear", overrun, 1);
        chk("set_beats_clear_word", word_out, 8'hA5);
        clear_err = 1; word_ready = 1; tick();
        clear_err = 0; word_ready = 0;
        chk("bp_drain", word_valid, 0);
        chk("bp_clear2", overrun, 0);

        begin_capture(1);
        send(8'hA5, 8, 0);
        chk("sim_word1", word_out, 8'hA5);
        send(8'h3C, 7, 0);
        in_valid = 1; serial_in = 0; word_ready = 1;
        tick();
        in_valid = 0; word_ready = 0;
        chk("sim_valid", word_valid, 1);
        chk("sim_word2", word_out, 8'h3C);
        chk("sim_ovr", overrun, 0);
        stop = 1; tick(); stop = 0;
        word_ready = 1; tick();
        chk("sim_drain", word_valid, 0);

        begin_capture(1);
        send(8'h3C, 8, 0);
        send(8'h5A, 8, 0);
        in_valid = 0;
        chk("ready_high_word", word_out, 8'h5A);
        chk("ready_high_ovr", overrun, 0);
        stop = 1; tick(); stop = 0;
        tick();

        word_ready = 0;
        begin_capture(0);
        send(8'hFF, 5, 0);
        in_valid = 0;
        chk("abort_cnt5", bit_cnt, 5);
        stop = 1; tick(); stop = 0;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", bit_cnt, 0);
        chk("abort_valid", word_valid, 0);
        begin_capture(0);
        send(8'hFF, 7, 0);
        in_valid = 1; serial_in = 1; stop = 1;
        tick();
        in_valid = 0; stop = 0;
        chk("abort8_valid", word_valid, 0);
        chk("abort8_busy", busy, 0);
        chk("abort8_cnt", bit_cnt, 0);
        chk("abort8_ovr", overrun, 0);

        begin_capture(1);
        send(8'hA5, 8, 0);
        send(8'h00, 3, 0);
        #3 rst_n = 0;
        #1;
        chk("midrst_valid", word_valid, 0);
        chk("midrst_word", word_out, 8'h00);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", bit_cnt, 0);
        in_valid = 0;
        tick();
        rst_n = 1;
        tick();
        chk("midrst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
